// File: rtl/id_scroll_display.sv
// Loadable N-digit ID register shown through a D-digit scanned 7-segment window,
// with optional wrap-around scrolling of the window offset.
module id_scroll_display #(
    parameter int                      NUM_DIGITS  = 8,
    parameter int                      DISP_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] ID_INIT     = 32'h13463723,
    parameter int                      REFRESH_DIV = 50000,
    parameter int                      SCROLL_DIV  = 25000000
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic                          Enable,
    input  logic                          Mode,
    input  logic                          ID_Load,
    input  logic [4*NUM_DIGITS-1:0]       ID_Data,
    output logic [DISP_DIGITS-1:0]        Anode,
    output logic [6:0]                    Segments,
    output logic [$clog2(NUM_DIGITS)-1:0] Position,
    output logic [3:0]                    Numeral
);
    localparam int PW   = $clog2(NUM_DIGITS);
    localparam int KW   = (DISP_DIGITS > 1) ? $clog2(DISP_DIGITS) : 1;
    localparam int RW   = $clog2(REFRESH_DIV);
    localparam int SW   = $clog2(SCROLL_DIV);
    localparam int SUMW = PW + 1;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    logic [4*NUM_DIGITS-1:0] id_q, id_d;
    logic [PW-1:0]           offset_q, offset_d;
    logic [KW-1:0]           k_q, k_d;
    logic [RW-1:0]           ref_cnt_q, ref_cnt_d;
    logic [SW-1:0]           scr_cnt_q, scr_cnt_d;
    logic [DISP_DIGITS-1:0]  anode_q, anode_d;
    logic [6:0]              seg_q, seg_d;
    logic [3:0]              num_q, num_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic                    ref_wrap, scr_run, scr_wrap;
    logic [SUMW-1:0]         sum, idx;

    always_comb begin
        ref_wrap  = (ref_cnt_q == RW'(REFRESH_DIV - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + RW'(1);
        k_d       = k_q;
        if (ref_wrap)
            k_d = (k_q >= KW'(DISP_DIGITS - 1)) ? '0 : k_q + KW'(1);

        scr_run   = Mode & Enable;
        scr_wrap  = scr_run && (scr_cnt_q == SW'(SCROLL_DIV - 1));
        id_d      = id_q;
        offset_d  = offset_q;
        scr_cnt_d = scr_cnt_q;
        // A load wins over a coincident scroll step and restarts the scroll period.
        if (ID_Load) begin
            id_d      = ID_Data;
            offset_d  = '0;
            scr_cnt_d = '0;
        end else if (scr_run) begin
            scr_cnt_d = scr_wrap ? '0 : scr_cnt_q + SW'(1);
            if (scr_wrap)
                offset_d = (offset_q == PW'(NUM_DIGITS - 1)) ? '0 : offset_q + PW'(1);
        end

        sum = {1'b0, offset_q} + SUMW'(k_q);
        idx = (sum >= SUMW'(NUM_DIGITS)) ? sum - SUMW'(NUM_DIGITS) : sum;
        num_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (idx == SUMW'(i)) num_d = id_q[4*(NUM_DIGITS-1-i) +: 4];

        anode_d = '1;
        for (int i = 0; i < DISP_DIGITS; i++)
            if (k_q == KW'(DISP_DIGITS - 1 - i)) anode_d[i] = 1'b0;

        seg_d = hex7(num_d);
        pos_d = offset_q;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            id_q      <= ID_INIT;
            offset_q  <= '0;
            k_q       <= '0;
            ref_cnt_q <= '0;
            scr_cnt_q <= '0;
            anode_q   <= '1;
            seg_q     <= 7'h7F;
            num_q     <= '0;
            pos_q     <= '0;
        end else begin
            id_q      <= id_d;
            offset_q  <= offset_d;
            k_q       <= k_d;
            ref_cnt_q <= ref_cnt_d;
            scr_cnt_q <= scr_cnt_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            num_q     <= num_d;
            pos_q     <= pos_d;
        end
    end

    assign Anode    = anode_q;
    assign Segments = seg_q;
    assign Numeral  = num_q;
    assign Position = pos_q;
endmodule

// File: tb/tb_id_scroll_display.sv
// Scoreboarded bench: a behavioural model pushes expected pins each cycle,
// popped after the edge; directed checks cover reset, scroll, pause, load and a 5/3 build.
module tb_id_scroll_display;
    localparam int N = 8, D = 4, RD = 2, SD = 8;

    logic        Clock = 1'b0, Reset_n = 1'b0, Enable = 1'b1, Mode = 1'b0, ID_Load = 1'b0;
    logic [31:0] ID_Data = '0;
    logic [3:0]  Anode, Numeral;
    logic [6:0]  Segments;
    logic [2:0]  Position;

    logic        ld5 = 1'b0;
    logic [19:0] data5 = '0;
    logic [2:0]  Anode5, Position5;
    logic [6:0]  Segments5;
    logic [3:0]  Numeral5;

    always #5 Clock = ~Clock;

    id_scroll_display #(.NUM_DIGITS(N), .DISP_DIGITS(D), .ID_INIT(32'h13463723),
                        .REFRESH_DIV(RD), .SCROLL_DIV(SD)) u_dut (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode), .ID_Load(ID_Load),
        .ID_Data(ID_Data), .Anode(Anode), .Segments(Segments), .Position(Position), .Numeral(Numeral));

    id_scroll_display #(.NUM_DIGITS(5), .DISP_DIGITS(3), .ID_INIT(20'h12345),
                        .REFRESH_DIV(RD), .SCROLL_DIV(SD)) u_dut5 (
        .Clock(Clock), .Reset_n(Reset_n), .Enable(Enable), .Mode(Mode), .ID_Load(ld5),
        .ID_Data(data5), .Anode(Anode5), .Segments(Segments5), .Position(Position5), .Numeral(Numeral5));

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int nchk = 0, nerr = 0, cyc = 0;
    logic [17:0] sb_q [$];
    int m_id [N];
    int m_off, m_k, m_ref, m_scr;
    bit mon5 = 1'b0;
    int prev5 = 0, seen5 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int kof(input logic [3:0] a, input int nd);
        for (int i = 0; i < nd; i++)
            if (!a[nd-1-i]) return i;
        return 0;
    endfunction

    task automatic load_model_id(input logic [31:0] v);
        for (int i = 0; i < N; i++) m_id[i] = int'((v >> (4*(N-1-i))) & 32'hF);
    endtask

    task automatic model_reset();
        load_model_id(32'h13463723);
        m_off = 0; m_k = 0; m_ref = 0; m_scr = 0;
        sb_q.delete();
    endtask

    // Push expected pins for the coming edge, advance the model, then compare.
    task automatic step();
        logic [3:0] an;
        int num;
        logic [17:0] got, want;
        an = 4'hF;
        an[D-1-m_k] = 1'b0;
        num = m_id[(m_off + m_k) % N];
        sb_q.push_back({an, seg_tab[num], 4'(num), 3'(m_off)});
        if (m_ref == RD - 1) begin m_ref = 0; m_k = (m_k + 1) % D; end
        else m_ref++;
        if (ID_Load) begin
            load_model_id(ID_Data); m_off = 0; m_scr = 0;
        end else if (Mode && Enable) begin
            if (m_scr == SD - 1) begin m_scr = 0; m_off = (m_off + 1) % N; end
            else m_scr++;
        end
        @(posedge Clock);
        #1;
        cyc++;
        got = {Anode, Segments, Numeral, Position};
        if (sb_q.size() == 0) chk("sb_empty", 0, 1);
        else begin
            want = sb_q.pop_front();
            chk("sb_pins", got, want);
        end
        chk("onehot", $countones(~Anode), 1);
        if (mon5) begin
            if (Position5 == 3'd4) begin
                int w5 [3] = '{5, 1, 2};
                chk("w5_num", Numeral5, w5[kof({1'b1, Anode5}, 3)]);
                seen5++;
            end
            if (prev5 == 4 && Position5 != 3'd4) chk("w5_wrap", Position5, 0);
            prev5 = Position5;
        end
    endtask

    initial begin
        logic [3:0] an_seq [8]  = '{4'h7, 4'h7, 4'hB, 4'hB, 4'hD, 4'hD, 4'hE, 4'hE};
        int         num_seq [8] = '{1, 1, 3, 3, 4, 4, 6, 6};
        logic [6:0] seg_seq [8] = '{7'h79, 7'h79, 7'h30, 7'h30, 7'h19, 7'h19, 7'h02, 7'h02};
        int p6 [4] = '{2, 3, 1, 3};
        logic [3:0] ld_num [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [6:0] ld_seg [4] = '{7'h08, 7'h03, 7'h46, 7'h21};
        int prevp, lastchg, t, n;

        model_reset();
        #11;
        chk("rst_an", Anode, 4'hF);
        chk("rst_seg", Segments, 7'h7F);
        chk("rst_num", Numeral, 0);
        chk("rst_pos", Position, 0);
        #1 Reset_n = 1'b1;

        // Static window
        Mode = 1'b0; Enable = 1'b1;
        for (int i = 0; i < 100; i++) begin step(); chk("st_pos", Position, 0); end

        // Asynchronous reset in the middle of a cycle
        #2 Reset_n = 1'b0;
        #1;
        chk("mrst_an", Anode, 4'hF);
        chk("mrst_seg", Segments, 7'h7F);
        chk("mrst_pos", Position, 0);
        model_reset();
        @(posedge Clock); #1;
        chk("mrst_hold", Anode, 4'hF);
        #2 Reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("rel_an", Anode, an_seq[i]);
            chk("rel_num", Numeral, num_seq[i]);
            chk("rel_seg", Segments, seg_seq[i]);
        end

        // Auto-scroll with wrap, plus the 5-digit/3-display build alongside
        Mode = 1'b1; Enable = 1'b1; mon5 = 1'b1; prev5 = Position5;
        prevp = Position; lastchg = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (Position != 3'(prevp)) begin
                chk("scr_inc", Position, (prevp + 1) % N);
                if (lastchg >= 0) chk("scr_per", cyc - lastchg, SD);
                lastchg = cyc;
                prevp = Position;
            end
            if (Position == 3'd6) chk("p6_num", Numeral, p6[kof(Anode, D)]);
        end
        mon5 = 1'b0;
        chk("w5_seen", seen5 > 0, 1);

        // Pause at position 3 part-way through a scroll period
        t = 0; while (Position != 3'd2 && t < 100) begin step(); t++; end
        chk("wait_p2", Position, 2);
        t = 0; while (Position != 3'd3 && t < 20) begin step(); t++; end
        chk("wait_p3", Position, 3);
        repeat (3) step();
        Enable = 1'b0;
        for (int i = 0; i < 20; i++) begin step(); chk("pause_pos", Position, 3); end
        Enable = 1'b1;
        n = 0; while (Position == 3'd3 && n < 20) begin step(); n++; end
        chk("resume_n", n, 5);
        chk("resume_pos", Position, 4);

        // Load coinciding with a scroll-counter wrap
        prevp = Position;
        t = 0; while (Position == 3'(prevp) && t < 20) begin step(); t++; end
        chk("wait_chg", Position != 3'(prevp), 1);
        repeat (6) step();
        ID_Data = 32'hABCDEF09; ID_Load = 1'b1;
        step();
        ID_Load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ld_pos", Position, 0);
            chk("ld_num", Numeral, ld_num[kof(Anode, D)]);
            chk("ld_seg", Segments, ld_seg[kof(Anode, D)]);
        end

        // Held load pins the offset at 0
        ID_Load = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin step(); chk("hold_pos", Position, 0); end
        ID_Load = 1'b0;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
